// File: rtl/rsp_mult_pkg.sv
// Shared encodings and saturation helpers for the rsp_mult pipelined multiplier.
package rsp_mult_pkg;

    // Operand interpretation selected by TC
    localparam logic TC_UNSIGNED = 1'b0;
    localparam logic TC_SIGNED   = 1'b1;

    // LSB handling selected by RND
    localparam logic RND_TRUNC   = 1'b0;
    localparam logic RND_HALF_UP = 1'b1;

    // Widest result a saturation constant can be built for
    localparam int SatMaxWidth = 64;

    // All-ones value of the given width, zero-extended to SatMaxWidth
    function automatic logic [SatMaxWidth-1:0] sat_unsigned(input int width);
        logic [SatMaxWidth-1:0] v;
        v = '0;
        for (int i = 0; i < SatMaxWidth; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Largest positive two's-complement value of the given width (0 then ones)
    function automatic logic [SatMaxWidth-1:0] sat_signed(input int width);
        logic [SatMaxWidth-1:0] v;
        v = '0;
        for (int i = 0; i < SatMaxWidth; i++) begin
            if (i < width - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rsp_mult_round_sat.sv
// Combinational round-half-up, MSB-aligned slice and optional saturation of a
// full-width product. Saturation and OVF exist only when RSP_MULT_SAT_EN is
// defined; otherwise the rounded value simply wraps and OVF is tied low.
module rsp_mult_round_sat
    import rsp_mult_pkg::*;
#(
    parameter int F       = 16,
    parameter int P_width = 15
) (
    input  logic [F-1:0]       full_i,
    input  logic               tc_i,
    input  logic               rnd_i,
    output logic [P_width-1:0] product_o,
    output logic               ovf_o
);

    localparam int D = F - P_width;

    // Rounded value, one bit wider so an unsigned carry-out is visible
    logic [F:0] sum;

    if (D > 0) begin : g_round
        localparam logic [F:0] Half = {{F{1'b0}}, 1'b1} << (D - 1);

        // Add half an output LSB when rounding is requested
        always_comb begin
            sum = {1'b0, full_i};
            if (rnd_i == RND_HALF_UP) sum = {1'b0, full_i} + Half;
        end
    end else begin : g_noround
        // Nothing is dropped, so rounding has no effect
        always_comb begin
            sum = {1'b0, full_i};
        end
    end

`ifdef RSP_MULT_SAT_EN
    localparam logic [SatMaxWidth-1:0] SatUFull = sat_unsigned(P_width);
    localparam logic [SatMaxWidth-1:0] SatSFull = sat_signed(P_width);
    localparam logic [P_width-1:0]     SatU     = SatUFull[P_width-1:0];
    localparam logic [P_width-1:0]     SatS     = SatSFull[P_width-1:0];

    logic ovf;

    // Detect rounding overflow and clamp to the largest representable value
    always_comb begin
        if (tc_i == TC_SIGNED) ovf = ~full_i[F-1] & sum[F-1];
        else                   ovf = sum[F];
        product_o = sum[F-1 -: P_width];
        if (ovf) product_o = (tc_i == TC_SIGNED) ? SatS : SatU;
        ovf_o = ovf;
    end
`else
    // Plain slice; any carry out of the rounding is discarded
    always_comb begin
        product_o = sum[F-1 -: P_width];
        ovf_o     = 1'b0;
    end
`endif

    // Dropped LSBs (and the carry / TC in the wrapping build) are intentionally unused
    logic unused_sum;
    assign unused_sum = ^{sum, tc_i};

endmodule

// File: rtl/rsp_mult_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready on both sides.
// DELAY register stages: DELAY-1 stages carry the exact product, the last one
// holds the rounded/sliced result. Saturation is compiled in by RSP_MULT_SAT_EN.
module rsp_mult_pipe
    import rsp_mult_pkg::*;
#(
    parameter int A_width = 8,
    parameter int B_width = 8,
    parameter int P_width = 15,
    parameter int DELAY   = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [A_width-1:0] A,
    input  logic [B_width-1:0] B,
    input  logic               TC,
    input  logic               RND,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [P_width-1:0] PRODUCT,
    output logic               OVF
);

    localparam int F = A_width + B_width;

    logic               out_valid_q;
    logic [P_width-1:0] product_q;
    logic               ovf_q;
    logic               stall;

    // Whole pipe freezes while the output beat is refused
    assign stall    = out_valid_q & ~OUT_READY;
    assign IN_READY = ~stall;

    // Operands extended to F+2 bits so one signed multiply covers both modes
    logic signed [F+1:0] a_w;
    logic signed [F+1:0] b_w;
    logic signed [F+1:0] prod_w;
    logic        [F-1:0] full_in;

    // Exact product of the incoming operands
    always_comb begin
        a_w     = {{(B_width + 2){A[A_width-1] & (TC == TC_SIGNED)}}, A};
        b_w     = {{(A_width + 2){B[B_width-1] & (TC == TC_SIGNED)}}, B};
        prod_w  = a_w * b_w;
        full_in = prod_w[F-1:0];
    end

    logic unused_prod;
    assign unused_prod = ^prod_w[F+1:F];

    // Beat presented to the rounding logic in front of the final register
    logic [F-1:0] rs_full;
    logic         rs_tc;
    logic         rs_rnd;
    logic         rs_vld;

    if (DELAY > 1) begin : g_stages
        localparam int NS = DELAY - 1;

        logic [F-1:0]  full_q [NS];
        logic [NS-1:0] tc_q;
        logic [NS-1:0] rnd_q;
        logic [NS-1:0] vld_q;

        // Shift product, mode bits and valid one stage per unstalled cycle
        always_ff @(posedge CLK) begin
            if (RST) begin
                vld_q <= '0;
                tc_q  <= '0;
                rnd_q <= '0;
                for (int i = 0; i < NS; i++) full_q[i] <= '0;
            end else if (!stall) begin
                full_q[0] <= full_in;
                tc_q[0]   <= TC;
                rnd_q[0]  <= RND;
                vld_q[0]  <= IN_VALID;
                for (int i = 1; i < NS; i++) begin
                    full_q[i] <= full_q[i-1];
                    tc_q[i]   <= tc_q[i-1];
                    rnd_q[i]  <= rnd_q[i-1];
                    vld_q[i]  <= vld_q[i-1];
                end
            end
        end

        assign rs_full = full_q[NS-1];
        assign rs_tc   = tc_q[NS-1];
        assign rs_rnd  = rnd_q[NS-1];
        assign rs_vld  = vld_q[NS-1];
    end else begin : g_direct
        assign rs_full = full_in;
        assign rs_tc   = TC;
        assign rs_rnd  = RND;
        assign rs_vld  = IN_VALID;
    end

    logic [P_width-1:0] product_d;
    logic               ovf_d;

    rsp_mult_round_sat #(
        .F       (F),
        .P_width (P_width)
    ) u_round_sat (
        .full_i    (rs_full),
        .tc_i      (rs_tc),
        .rnd_i     (rs_rnd),
        .product_o (product_d),
        .ovf_o     (ovf_d)
    );

    // Final stage: registered result, flag and valid
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            product_q   <= '0;
            ovf_q       <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= rs_vld;
            product_q   <= product_d;
            ovf_q       <= ovf_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign PRODUCT   = product_q;
    assign OVF       = ovf_q;

endmodule
